// File: rtl/serial_pair_word_serializer_if.sv
// Word-pair handshake in, two framed serial bit lines out.
// master = upstream producer / serial consumer side, slave = the serializer.
interface serial_pair_word_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             a;
    logic             b;
    logic             out_valid;
    logic             out_first;
    logic             out_last;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, a, b, out_valid, out_first, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, a, b, out_valid, out_first, out_last
    );
endinterface

// File: rtl/serial_pair_word_serializer.sv
// Purpose: serializes (A,B) word pairs onto two bit lines, MSB first (LSB first with SERIAL_PAIR_LSB_FIRST_EN).
// Latency: first bit the cycle after transfer when the shifter is free; one bit per cycle, gapless back-to-back.
// Backpressure: one-entry holding buffer; in_ready = ~pend_valid, purely registered.
module serial_pair_word_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_pair_word_serializer_if.slave  bus
);
    localparam int            CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic          SINGLE = (WIDTH == 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [WIDTH-1:0] pend_a, pend_b;
    logic             pend_valid;
    logic [CW-1:0]    cnt;
    logic             first_q, last_q;

    logic             shifting, xfer, free;
    logic [CW-1:0]    cnt_nxt;

    assign shifting = (state == SHIFT);
    assign xfer     = bus.in_valid & ~pend_valid;
    assign free     = ~shifting | last_q;
    assign cnt_nxt  = cnt + 1'b1;

    assign bus.in_ready  = ~pend_valid;
    assign bus.out_valid = shifting;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;

    // Shifters are zeroed in IDLE, so the serial lines read 0 there without gating.
`ifdef SERIAL_PAIR_LSB_FIRST_EN
    assign bus.a = sh_a[0];
    assign bus.b = sh_b[0];
`else
    assign bus.a = sh_a[WIDTH-1];
    assign bus.b = sh_b[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sh_a       <= '0;
            sh_b       <= '0;
            cnt        <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            pend_a     <= '0;
            pend_b     <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (free) begin
                if (pend_valid) begin
                    state   <= SHIFT;
                    sh_a    <= pend_a;
                    sh_b    <= pend_b;
                    cnt     <= '0;
                    first_q <= 1'b1;
                    last_q  <= SINGLE;
                end else if (xfer) begin
                    state   <= SHIFT;
                    sh_a    <= bus.in_a;
                    sh_b    <= bus.in_b;
                    cnt     <= '0;
                    first_q <= 1'b1;
                    last_q  <= SINGLE;
                end else begin
                    state   <= IDLE;
                    sh_a    <= '0;
                    sh_b    <= '0;
                    cnt     <= '0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            end else begin
`ifdef SERIAL_PAIR_LSB_FIRST_EN
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
`else
                sh_a <= sh_a << 1;
                sh_b <= sh_b << 1;
`endif
                cnt     <= cnt_nxt;
                first_q <= 1'b0;
                last_q  <= (cnt_nxt == LAST);
            end

            // A transfer parks in pend unless it went straight into a free, empty-pend shifter.
            if (xfer && (!free || pend_valid)) begin
                pend_a     <= bus.in_a;
                pend_b     <= bus.in_b;
                pend_valid <= 1'b1;
            end else if (free && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_pair_word_serializer.sv
// Bench for serial_pair_word_serializer: vector table, hand sequences, randomized traffic vs word-queue model.
module tb_serial_pair_word_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_pair_word_serializer_if #(.WIDTH(8)) i8 ();
    serial_pair_word_serializer_if #(.WIDTH(1)) i1 ();

    serial_pair_word_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(i8.slave));
    serial_pair_word_serializer #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    typedef struct {
        logic       v;
        logic [7:0] ia;
        logic [7:0] ib;
        logic [5:0] exp; // {in_ready, out_valid, a, b, out_first, out_last}
    } vec_t;

    vec_t  tbl[$];
    pair_t exp_q[$];
    int    bitpos  = 0;
    int    run     = 0;
    int    max_run = 0;
    int    unst;
    logic [7:0] rec_a, rec_b;
    pair_t      head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position of the k-th emitted bit within its word.
    function automatic int bidx(input int k);
`ifdef SERIAL_PAIR_LSB_FIRST_EN
        return k;
`else
        return 7 - k;
`endif
    endfunction

    function automatic logic ebit(input logic [7:0] w, input int k);
        return w[bidx(k)];
    endfunction

    function automatic logic [1:0] rel(input logic [7:0] x, input logic [7:0] y);
        return (x > y) ? 2'd2 : ((x == y) ? 2'd1 : 2'd0);
    endfunction

    function automatic logic [5:0] pk8();
        return {i8.in_ready, i8.out_valid, i8.a, i8.b, i8.out_first, i8.out_last};
    endfunction

    function automatic logic [5:0] pk1();
        return {i1.in_ready, i1.out_valid, i1.a, i1.b, i1.out_first, i1.out_last};
    endfunction

    task automatic add_row(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                           input logic rdy, input logic [7:0] wa, input logic [7:0] wb, input int k);
        vec_t r;
        r.v  = v;
        r.ia = ia;
        r.ib = ib;
        if (k < 0) r.exp = {rdy, 5'b00000};
        else       r.exp = {rdy, 1'b1, ebit(wa, k), ebit(wb, k), (k == 0), (k == 7)};
        tbl.push_back(r);
    endtask

    // Model: queue of accepted words; head is the word on the wire, anything behind it is parked.
    always @(negedge clk) begin
        if (rst) begin
            unst = exp_q.size() - (i8.out_valid ? 1 : 0);
            check("out_valid", 32'(i8.out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(i8.in_ready), 32'(unst <= 0));
            if (i8.out_valid && exp_q.size() != 0) begin
                head = exp_q[0];
                check("ser_bits", 32'({i8.a, i8.b}), 32'({ebit(head.a, bitpos), ebit(head.b, bitpos)}));
                check("framing", 32'({i8.out_first, i8.out_last}), 32'({bitpos == 0, bitpos == 7}));
                rec_a[bidx(bitpos)] = i8.a;
                rec_b[bidx(bitpos)] = i8.b;
                bitpos++;
                if (bitpos == 8) begin
                    check("word", 32'({rec_a, rec_b}), 32'(head));
                    check("cmp_relation", 32'(rel(rec_a, rec_b)), 32'(rel(head.a, head.b)));
                    void'(exp_q.pop_front());
                    bitpos = 0;
                end
            end else if (!i8.out_valid) begin
                check("idle_lines", 32'({i8.a, i8.b, i8.out_first, i8.out_last}), 32'd0);
            end
            if (i8.out_valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (i8.in_valid && i8.in_ready) exp_q.push_back({i8.in_a, i8.in_b});
        end
    end

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the word.
    task automatic send_word(input logic [7:0] wa, input logic [7:0] wb);
        bit got = 1'b0;
        i8.in_valid = 1'b1;
        i8.in_a     = wa;
        i8.in_b     = wb;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (i8.in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        check("send_accept", 32'(got), 32'd1);
    endtask

    task automatic drain();
        i8.in_valid = 1'b0;
        for (int t = 0; t < 60 && (exp_q.size() != 0 || i8.out_valid); t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i8.in_valid = 1'b0; i8.in_a = '0; i8.in_b = '0;
        i1.in_valid = 1'b0; i1.in_a = '0; i1.in_b = '0;

        // Reset state
        #3;
        check("rst_outputs8", 32'(pk8()), 32'(6'b100000));
        check("rst_outputs1", 32'(pk1()), 32'(6'b100000));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold8", 32'(pk8()), 32'(6'b100000));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst8", 32'(pk8()), 32'(6'b100000));
        check("post_rst1", 32'(pk1()), 32'(6'b100000));

        // Single word, then backpressure with a second word offered during bit 2
        add_row(1'b1, 8'hA5, 8'h3C, 1'b1, 8'h00, 8'h00, -1);
        for (int k = 0; k < 8; k++) add_row(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 8'h3C, k);
        add_row(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, -1);
        add_row(1'b1, 8'hC3, 8'h81, 1'b1, 8'h00, 8'h00, -1);
        add_row(1'b0, 8'h00, 8'h00, 1'b1, 8'hC3, 8'h81, 0);
        add_row(1'b0, 8'h00, 8'h00, 1'b1, 8'hC3, 8'h81, 1);
        add_row(1'b1, 8'h96, 8'h0F, 1'b1, 8'hC3, 8'h81, 2);
        for (int k = 3; k < 8; k++) add_row(1'b0, 8'h00, 8'h00, 1'b0, 8'hC3, 8'h81, k);
        for (int k = 0; k < 8; k++) add_row(1'b0, 8'h00, 8'h00, 1'b1, 8'h96, 8'h0F, k);
        add_row(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, -1);

        for (int i = 0; i < tbl.size(); i++) begin
            i8.in_valid = tbl[i].v;
            i8.in_a     = tbl[i].ia;
            i8.in_b     = tbl[i].ib;
            @(negedge clk);
            check($sformatf("tbl_row%0d", i), 32'(pk8()), 32'(tbl[i].exp));
            @(posedge clk);
            #1;
        end

        // Back-to-back: three words with in_valid held high
        max_run = 0;
        send_word(8'h12, 8'hF0);
        send_word(8'hE1, 8'h0E);
        send_word(8'h7B, 8'hB7);
        drain();
        check("b2b_gapless", 32'(max_run >= 24), 32'd1);

        // Comparator stimulus: greater, equal, less
        send_word(8'h80, 8'h7F);
        send_word(8'h55, 8'h55);
        send_word(8'h01, 8'h02);
        drain();

        // Reset during bit 4 with a word parked in pend
        send_word(8'h5A, 8'hE7);
        send_word(8'h11, 8'h22);
        i8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_word_busy", 32'({i8.out_valid, i8.in_ready}), 32'(2'b10));
        rst = 1'b0;
        #1;
        check("rst_mid_word", 32'(pk8()), 32'(6'b100000));
        exp_q.delete();
        bitpos = 0;
        run    = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("no_leftover", 32'(pk8()), 32'(6'b100000));
        @(posedge clk);
        #1;

        // Randomized traffic with random gaps
        for (int w = 0; w < 150; w++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (w % 37 == 0) gap = 12;
            i8.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                i8.in_a = 8'($urandom);
                i8.in_b = 8'($urandom);
                @(posedge clk);
                #1;
            end
            send_word(8'($urandom), 8'($urandom));
        end
        drain();

        // WIDTH = 1: two back-to-back single-bit words
        i1.in_valid = 1'b1;
        i1.in_a     = 1'b1;
        i1.in_b     = 1'b0;
        @(negedge clk);
        check("w1_ready", 32'(i1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        i1.in_a = 1'b0;
        i1.in_b = 1'b1;
        @(negedge clk);
        check("w1_word0", 32'(pk1()), 32'(6'b111011));
        @(posedge clk);
        #1;
        i1.in_valid = 1'b0;
        @(negedge clk);
        check("w1_word1", 32'(pk1()), 32'(6'b110111));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w1_idle", 32'(pk1()), 32'(6'b100000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
